// File: rtl/fetch_pkg.sv
// Shared types and constants for the predicting fetch stage: BTB entry layout,
// 2-bit predictor states, index-width helper and the instruction ROM image.
package fetch_pkg;

   localparam int XLEN = 32;

   localparam logic [1:0] SNT = 2'b00;
   localparam logic [1:0] WNT = 2'b01;
   localparam logic [1:0] WT  = 2'b10;
   localparam logic [1:0] ST  = 2'b11;

   // Tag and target are stored at full XLEN; narrower tags are zero-extended.
   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] tag;
      logic [XLEN-1:0] target;
      logic [1:0]      cnt;
   } btb_entry_t;

   function automatic int idx_bits(input int entries);
      return $clog2(entries);
   endfunction

   function automatic logic [1:0] sat_inc(input logic [1:0] c);
      return (c == ST) ? ST : c + 2'd1;
   endfunction

   function automatic logic [1:0] sat_dec(input logic [1:0] c);
      return (c == SNT) ? SNT : c - 2'd1;
   endfunction

   localparam int IMEM_AW = 4;
   localparam logic [31:0] IMEM_ROM [16] = '{
      32'h00000013, 32'h00100093, 32'h00200113, 32'h00308193,
      32'h00410213, 32'h00518293, 32'h00620313, 32'h00728393,
      32'h00830413, 32'h00938493, 32'h00a40513, 32'h00b48593,
      32'h00c50613, 32'h00d58693, 32'hfe000ee3, 32'h0000006f
   };

endpackage

// File: rtl/fetch_predict_if.sv
// Fetch-stage bus: hazard/Execute inputs towards fetch and the fetch outputs
// towards the F/D register and performance monitoring.
interface fetch_predict_if #(
   parameter int WIDTH     = 32,
   parameter int CNT_WIDTH = 32
);
   logic                 StallF;
   logic                 UpdateE;
   logic                 TakenE;
   logic [WIDTH-1:0]     PCE;
   logic [WIDTH-1:0]     PCTargetE;
   logic                 MispredictE;
   logic [WIDTH-1:0]     PCCorrectE;
   logic [WIDTH-1:0]     InstrF;
   logic [WIDTH-1:0]     PCF;
   logic [WIDTH-1:0]     PCPlus4F;
   logic                 PredTakenF;
   logic [WIDTH-1:0]     PredTargetF;
   logic [CNT_WIDTH-1:0] BranchCount;
   logic [CNT_WIDTH-1:0] MispredictCount;

   modport master (
      output StallF, UpdateE, TakenE, PCE, PCTargetE, MispredictE, PCCorrectE,
      input  InstrF, PCF, PCPlus4F, PredTakenF, PredTargetF, BranchCount, MispredictCount
   );

   modport slave (
      input  StallF, UpdateE, TakenE, PCE, PCTargetE, MispredictE, PCCorrectE,
      output InstrF, PCF, PCPlus4F, PredTakenF, PredTargetF, BranchCount, MispredictCount
   );
endinterface

// File: rtl/fetch_predict_btb.sv
// Direct-mapped branch target buffer with 2-bit saturating predictors.
// Lookup is combinational; training from Execute lands on the next clock edge.
module fetch_predict_btb
   import fetch_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int BTB_ENTRIES = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] lookup_pc_i,
   input  logic             upd_i,
   input  logic             upd_taken_i,
   input  logic [WIDTH-1:0] upd_pc_i,
   input  logic [WIDTH-1:0] upd_target_i,
   output logic             pred_taken_o,
   output logic [WIDTH-1:0] pred_target_o
);
   localparam int IDX   = idx_bits(BTB_ENTRIES);
   localparam int TAG_W = WIDTH - IDX - 2;

   btb_entry_t       entry_q [BTB_ENTRIES];
   btb_entry_t       rd_entry;
   btb_entry_t       wr_entry;
   btb_entry_t       wr_entry_d;
   logic             wr_en;
   logic [IDX-1:0]   rd_idx;
   logic [IDX-1:0]   wr_idx;
   logic [TAG_W-1:0] rd_tag;
   logic [TAG_W-1:0] wr_tag;
   logic             rd_hit;
   logic             wr_hit;
   logic             unused_pc_bits;

   assign unused_pc_bits = ^{lookup_pc_i[1:0], upd_pc_i[1:0]};

   assign rd_idx   = lookup_pc_i[IDX+1:2];
   assign rd_tag   = lookup_pc_i[WIDTH-1:IDX+2];
   assign wr_idx   = upd_pc_i[IDX+1:2];
   assign wr_tag   = upd_pc_i[WIDTH-1:IDX+2];

   assign rd_entry = entry_q[rd_idx];
   assign wr_entry = entry_q[wr_idx];
   assign rd_hit   = rd_entry.valid && (rd_entry.tag == XLEN'(rd_tag));
   assign wr_hit   = wr_entry.valid && (wr_entry.tag == XLEN'(wr_tag));

   // Same-cycle read/write of one index sees the old entry: no bypass.
   assign pred_taken_o  = rd_hit && rd_entry.cnt[1];
   assign pred_target_o = rd_entry.target[WIDTH-1:0];

   always_comb begin
      wr_en      = 1'b0;
      wr_entry_d = wr_entry;
      if (upd_i) begin
         if (wr_hit) begin
            wr_en = 1'b1;
            if (upd_taken_i) begin
               wr_entry_d.cnt    = sat_inc(wr_entry.cnt);
               wr_entry_d.target = XLEN'(upd_target_i);
            end else begin
               wr_entry_d.cnt    = sat_dec(wr_entry.cnt);
            end
         end else if (upd_taken_i) begin
            wr_en             = 1'b1;
            wr_entry_d.valid  = 1'b1;
            wr_entry_d.tag    = XLEN'(wr_tag);
            wr_entry_d.target = XLEN'(upd_target_i);
            wr_entry_d.cnt    = WT;
         end
      end
   end

   // Only valid bits are cleared; payload fields are don't-care until allocated.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < BTB_ENTRIES; i++) begin
            entry_q[i].valid <= 1'b0;
         end
      end else if (wr_en) begin
         entry_q[wr_idx] <= wr_entry_d;
      end
   end

endmodule

// File: rtl/fetch_predict.sv
// Predicting fetch stage: PC register steered by the BTB, Execute redirect,
// instruction ROM read and saturating branch/mispredict event counters.
module fetch_predict
   import fetch_pkg::*;
#(
   parameter int               WIDTH       = 32,
   parameter int               BTB_ENTRIES = 16,
   parameter logic [WIDTH-1:0] RESET_PC    = '0,
   parameter int               CNT_WIDTH   = 32
) (
   input logic           clk,
   input logic           rst,
   fetch_predict_if.slave bus
);
   logic [WIDTH-1:0]     pc_q;
   logic [WIDTH-1:0]     pc_d;
   logic [WIDTH-1:0]     pc_plus4;
   logic [WIDTH-1:0]     btb_target;
   logic [WIDTH-1:0]     pred_target;
   logic                 pred_taken;
   logic [CNT_WIDTH-1:0] branch_cnt_q;
   logic [CNT_WIDTH-1:0] branch_cnt_d;
   logic [CNT_WIDTH-1:0] misp_cnt_q;
   logic [CNT_WIDTH-1:0] misp_cnt_d;

   fetch_predict_btb #(
      .WIDTH       (WIDTH),
      .BTB_ENTRIES (BTB_ENTRIES)
   ) u_btb (
      .clk           (clk),
      .rst           (rst),
      .lookup_pc_i   (pc_q),
      .upd_i         (bus.UpdateE),
      .upd_taken_i   (bus.TakenE),
      .upd_pc_i      (bus.PCE),
      .upd_target_i  (bus.PCTargetE),
      .pred_taken_o  (pred_taken),
      .pred_target_o (btb_target)
   );

   assign pc_plus4    = pc_q + WIDTH'(4);
   assign pred_target = pred_taken ? btb_target : pc_plus4;

   // Execute redirect beats the hazard-unit stall.
   always_comb begin
      pc_d = pred_target;
      if (bus.MispredictE) begin
         pc_d = bus.PCCorrectE;
      end else if (bus.StallF) begin
         pc_d = pc_q;
      end
   end

   always_comb begin
      branch_cnt_d = branch_cnt_q;
      misp_cnt_d   = misp_cnt_q;
      if (bus.UpdateE && !(&branch_cnt_q)) begin
         branch_cnt_d = branch_cnt_q + CNT_WIDTH'(1);
      end
      if (bus.MispredictE && !(&misp_cnt_q)) begin
         misp_cnt_d = misp_cnt_q + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q         <= RESET_PC;
         branch_cnt_q <= '0;
         misp_cnt_q   <= '0;
      end else begin
         pc_q         <= pc_d;
         branch_cnt_q <= branch_cnt_d;
         misp_cnt_q   <= misp_cnt_d;
      end
   end

   // Instruction memory is a word-addressed ROM that aliases beyond its depth.
   assign bus.InstrF          = WIDTH'(IMEM_ROM[pc_q[IMEM_AW+1:2]]);
   assign bus.PCF             = pc_q;
   assign bus.PCPlus4F        = pc_plus4;
   assign bus.PredTakenF      = pred_taken;
   assign bus.PredTargetF     = pred_target;
   assign bus.BranchCount     = branch_cnt_q;
   assign bus.MispredictCount = misp_cnt_q;

endmodule

// File: doc/fetch_predict.md
Name: fetch_predict

Overview:
Parametrised fetch stage that replaces the fixed PC+4/PCTarget selection with a direct-mapped branch target buffer (BTB) and per-entry 2-bit saturating predictors. It predicts the next PC in the fetch cycle and is trained by control-transfer resolutions from Execute. Execute's mispredict redirect overrides everything else. The block sits between the hazard unit/Execute stage and the F/D pipeline register. It also keeps saturating performance counters for branch and mispredict events.

Parameters:
WIDTH, 32, address/instruction width in bits
BTB_ENTRIES, 16, number of BTB entries; power of two, at least 2
RESET_PC, 32'h0000_0000, PC value loaded on reset
CNT_WIDTH, 32, width of each performance counter

Ports:
clk  in  1  clock; all state updates on its rising edge
rst  in  1  reset, synchronous, active-high
StallF  in  1  hold PCF (hazard unit)
UpdateE  in  1  a branch/jump resolved in Execute this cycle
TakenE  in  1  resolved direction of that instruction
PCE  in  WIDTH  PC of the resolving instruction
PCTargetE  in  WIDTH  resolved taken target
MispredictE  in  1  Execute detected a wrong prediction (direction or target)
PCCorrectE  in  WIDTH  correct next PC when MispredictE=1
InstrF  out  WIDTH  instruction at PCF (combinational instr_mem read)
PCF  out  WIDTH  current fetch PC
PCPlus4F  out  WIDTH  PCF+4
PredTakenF  out  1  prediction for PCF, forwarded down the pipe
PredTargetF  out  WIDTH  predicted next PC (BTB target or PCPlus4F)
BranchCount  out  CNT_WIDTH  count of UpdateE cycles
MispredictCount  out  CNT_WIDTH  count of MispredictE cycles

Behaviour:
- Index and tag: IDX = log2(BTB_ENTRIES). Index = PC[IDX+1:2]. Tag = PC[WIDTH-1:IDX+2]. PC[1:0] is ignored.
- Entry contents: valid, tag, target[WIDTH-1:0], cnt[1:0].
- Prediction is combinational from PCF: hit = valid && tag match. PredTakenF = hit && cnt[1]. PredTargetF = PredTakenF ? target : PCPlus4F.
- PC register next-value priority: rst -> RESET_PC; else MispredictE -> PCCorrectE (wins even when StallF=1); else StallF -> hold; else PredTargetF.
- Training on UpdateE, applied at the clock edge:
  - Hit and TakenE: cnt saturating +1; target <= PCTargetE.
  - Hit and not TakenE: cnt saturating -1; target unchanged.
  - Miss and TakenE: allocate/overwrite the entry with valid=1, new tag, target=PCTargetE, cnt=2'b10.
  - Miss and not TakenE: no change.
- Training is independent of StallF.
- Same-cycle read and write of one index: the prediction uses the pre-update contents; there is no bypass.
- Latency: a trained entry affects prediction from the next cycle.
- MispredictE without UpdateE is legal. It redirects the PC only and leaves the BTB unchanged.
- Reset:
  - PCF = RESET_PC.
  - All valid bits cleared, so PredTakenF = 0 and PredTargetF = RESET_PC+4 in the first cycle after reset.
  - BranchCount = MispredictCount = 0.
  - Targets, tags and counters need not be reset.
  - A reset asserted mid-operation discards any same-cycle UpdateE and MispredictE.
- Counters: increment by 1 on UpdateE and MispredictE respectively, and saturate at all-ones with no wrap.
- Address arithmetic: PCPlus4F wraps modulo 2^WIDTH, so all-ones minus 3 plus 4 gives 0.

Decomposition:
- Package fetch_pkg holds the btb_entry_t struct (valid, tag, target, cnt), the 2-bit counter constants (SNT=00, WNT=01, WT=10, ST=11) and a clog2-based IDX helper.
- Sub-module btb (storage, lookup and training) is the natural split.
- Reuse the existing adder, pc_reg (with stall) and instr_mem.

Test Plan:
- Reset: after reset, PCF=0, InstrF=mem[0], PredTakenF=0; with no stall, PCF steps 0->4->8.
- Allocation: UpdateE=1, TakenE=1, PCE=0x10, PCTargetE=0x40. The next time PCF=0x10, PredTakenF=1 and the following PCF is 0x40.
- Saturation and training: from WT, three not-taken updates at PCE=0x10 give cnt WNT then SNT then SNT, and PredTargetF=0x14. Four taken updates give ST and stay at ST.
- Aliasing with BTB_ENTRIES=16: the entry for 0x10 is trained. Then PCF=0x50 (same index, different tag) gives no hit and PredTargetF=0x54. A taken update at 0x50 replaces the entry.
- Redirect priority: StallF=1 with MispredictE=1 and PCCorrectE=0x80 gives PCF=0x80 the next cycle, and MispredictCount increments by 1.
- Counters and reset mid-run: preload near all-ones with CNT_WIDTH=4; BranchCount holds at 15. Asserting rst with UpdateE=1 at PCE=0x10 leaves no valid entry at 0x10 afterwards.
